// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, tracker slot, forward selects.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package pipe_pkg;

    // Register address width; register 0 is hard-wired zero and never hazards.
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    // One in-flight instruction as seen by the hazard tracker.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } slot_t;

    // EXEC operand source encodings.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // True when the slot writes the register the ID instruction actually reads.
    function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] src,
                                        input logic use_src);
        return s.valid && s.we && (s.rd == src) && (src != '0) && use_src;
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Compares one ID source register against the EX/MEM/WB tracker slots; instantiated once per source.
// Latency: purely combinational.
// Backpressure: none; the hazard output is what the sequencer uses to hold the front end.
// Build option FORWARDING_EN: defined -> only load-use in EX hazards and forward selects are produced;
// undefined -> any in-flight writer hazards and the forward select is always the register file.
// Ports: ex_slot/mem_slot/wb_slot tracker contents, src/use_src the ID source, hazard, fwd_sel.
module pipe_hazard_detect
    import pipe_pkg::*;
(
    input  slot_t             ex_slot,
    input  slot_t             mem_slot,
    input  slot_t             wb_slot,
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    output logic              hazard,
    output logic [1:0]        fwd_sel
);

    logic m_ex;
    logic m_mem;
    logic m_wb;

    assign m_ex  = slot_match(ex_slot,  src, use_src);
    assign m_mem = slot_match(mem_slot, src, use_src);
    assign m_wb  = slot_match(wb_slot,  src, use_src);

`ifdef FORWARDING_EN
    // A load in EX has no data yet, everything else can be bypassed.
    assign hazard  = m_ex && ex_slot.ld;
    // EX moves to MEM as this instruction enters EXEC; youngest producer wins.
    assign fwd_sel = m_ex ? FWD_MEM : (m_mem ? FWD_WB : FWD_RF);

    logic unused_bits;
    assign unused_bits = ^{m_wb, mem_slot.ld, wb_slot.ld};
`else
    assign hazard  = m_ex || m_mem || m_wb;
    assign fwd_sel = FWD_RF;

    logic unused_bits;
    assign unused_bits = ^{ex_slot.ld, mem_slot.ld, wb_slot.ld};
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: RAW hazard stalls, branch flushes, optional operand forwarding.
// Latency: stage enables combinational from state/hazard/branch; fwd_a/fwd_b/stall_cnt registered (1 cycle).
// Backpressure: a hazard drops pc_en/ifid_en and bubbles ID/EX until the producer retires or bypasses.
// Build option FORWARDING_EN enables the load-use-only stall rule and the registered forward selects.
// Ports: ID instruction fields (id_*), ex_branch_taken in; pc_en, ifid_en, idex_bubble, flush,
//        fwd_a, fwd_b, stall_cnt out. REG_AW comes from pipe_pkg.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int INIT_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_write_reg,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_bubble,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] init_cnt;
    slot_t         ex_slot;
    slot_t         mem_slot;
    slot_t         wb_slot;
    slot_t         id_slot;
    logic          haz_rs;
    logic          haz_rt;
    logic          hazard;
    logic [1:0]    fwd_sel_rs;
    logic [1:0]    fwd_sel_rt;
    logic          issue;
    logic          stall;

    pipe_hazard_detect u_det_rs (
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .src      (id_rs),
        .use_src  (id_use_rs),
        .hazard   (haz_rs),
        .fwd_sel  (fwd_sel_rs)
    );

    pipe_hazard_detect u_det_rt (
        .ex_slot  (ex_slot),
        .mem_slot (mem_slot),
        .wb_slot  (wb_slot),
        .src      (id_rt),
        .use_src  (id_use_rt),
        .hazard   (haz_rt),
        .fwd_sel  (fwd_sel_rt)
    );

    // An empty ID stage cannot be blocked; rs and rt together still cost one stall cycle.
    assign hazard  = id_valid && (haz_rs || haz_rt);
    assign id_slot = '{valid: 1'b1, we: id_reg_write, rd: id_write_reg, ld: id_mem_read};

    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        flush       = 1'b0;
        issue       = 1'b0;
        stall       = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN, STALL: begin
                if (ex_branch_taken) begin
                    // Taken branch wins over any stall: load target, squash IF/ID and ID.
                    flush     = 1'b1;
                    pc_en     = 1'b1;
                    ifid_en   = 1'b1;
                    state_nxt = RUN;
                end else if (hazard) begin
                    stall     = 1'b1;
                    state_nxt = STALL;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_bubble = 1'b0;
                    issue       = id_valid;
                    state_nxt   = RUN;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            ex_slot   <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            stall_cnt <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
        end else begin
            state <= state_nxt;
            if (state == INIT && init_cnt != INIT_LAST) begin
                init_cnt <= init_cnt + IW'(1);
            end else begin
                init_cnt <= '0;
            end
            if (state != INIT) begin
                wb_slot  <= mem_slot;
                mem_slot <= ex_slot;
                ex_slot  <= issue ? id_slot : '0;
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            // Selects belong to the instruction entering EXEC; bubbles read the register file.
            fwd_a <= issue ? fwd_sel_rs : FWD_RF;
            fwd_b <= issue ? fwd_sel_rt : FWD_RF;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit valid;
        bit we;
        int rd;
        bit ld;
    } instr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, ex_branch_taken;
    logic [REG_AW-1:0] id_rs, id_rt, id_write_reg;
    logic pc_en, ifid_en, idex_bubble, flush;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.INIT_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_reg_write    (id_reg_write),
        .id_write_reg    (id_write_reg),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_bubble     (idex_bubble),
        .flush           (flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt)
    );

    task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                          input bit we, input int wr, input bit ld, input bit br);
        id_valid        = v;
        id_rs           = REG_AW'(rs);
        id_use_rs       = urs;
        id_rt           = REG_AW'(rt);
        id_use_rt       = urt;
        id_reg_write    = we;
        id_write_reg    = REG_AW'(wr);
        id_mem_read     = ld;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step after the edge that starts the first RUN cycle.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) next_cycle();
    endtask

    // Samples each cycle until the front end advances; bounded to 8 cycles.
    task automatic run_until_issue(output int stalls, output bit ok);
        stalls = 0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pc_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            stalls++;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (pc_en !== 1'b0 || ifid_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got pc_en=%b ifid_en=%b want 0 0", pc_en, ifid_en); end
        n_cmp++; if (idex_bubble !== 1'b1 || flush !== 1'b0) begin n_bad++; $display("FAIL reset_bub: got bubble=%b flush=%b want 1 0", idex_bubble, flush); end
        n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stall_cnt !== '0) begin n_bad++; $display("FAIL reset_regs: got fwd=%0d/%0d cnt=%0d want 0/0 0", fwd_a, fwd_b, stall_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // A taken branch during INIT must not flush.
            set_id(1, 1, 1, 2, 1, 1, 4, 0, (i < 3));
            @(negedge clk);
            n_cmp++; if (pc_en !== (i == 3)) begin n_bad++; $display("FAIL init_pc cyc%0d: got %b want %b", i + 1, pc_en, (i == 3)); end
            n_cmp++; if (idex_bubble !== (i != 3)) begin n_bad++; $display("FAIL init_bubble cyc%0d: got %b want %b", i + 1, idex_bubble, (i != 3)); end
            n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL init_flush cyc%0d: got %b want 0", i + 1, flush); end
            next_cycle();
        end
        idle();
        @(negedge clk);
        n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL init_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_raw();
        int stalls;
        bit ok;
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 3, 0, 0);          // add r3
        @(negedge clk);
        n_cmp++; if (pc_en !== 1'b1) begin n_bad++; $display("FAIL raw_first: got pc_en=%b want 1", pc_en); end
        next_cycle();
        set_id(1, 3, 1, 4, 1, 1, 4, 0, 0);          // sub r4 reads r3
        run_until_issue(stalls, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL raw_release: got no issue in 8 cycles want issue"); end
        n_cmp++; if (stalls != (FWD ? 0 : 3)) begin n_bad++; $display("FAIL raw_stalls: got %0d want %0d", stalls, FWD ? 0 : 3); end
        n_cmp++; if (stall_cnt !== CNT_W'(FWD ? 0 : 3)) begin n_bad++; $display("FAIL raw_cnt: got %0d want %0d", stall_cnt, FWD ? 0 : 3); end
        next_cycle();
        idle();
        @(negedge clk);
        n_cmp++; if (fwd_a !== 2'(FWD ? 1 : 0) || fwd_b !== 2'd0) begin n_bad++; $display("FAIL raw_fwd: got %0d/%0d want %0d/0", fwd_a, fwd_b, FWD ? 1 : 0); end
    endtask

    task automatic test_load_use();
        int stalls;
        bit ok;
        do_reset();
        set_id(1, 1, 0, 2, 0, 1, 5, 1, 0);          // lw r5
        next_cycle();
        set_id(1, 5, 1, 5, 1, 1, 6, 0, 0);          // add r6,r5,r5
        run_until_issue(stalls, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL lu_release: got no issue in 8 cycles want issue"); end
        n_cmp++; if (stalls != (FWD ? 1 : 3)) begin n_bad++; $display("FAIL lu_stalls: got %0d want %0d", stalls, FWD ? 1 : 3); end
        next_cycle();
        idle();
        @(negedge clk);
        n_cmp++; if (fwd_a !== 2'(FWD ? 2 : 0) || fwd_b !== 2'(FWD ? 2 : 0)) begin n_bad++; $display("FAIL lu_fwd: got %0d/%0d want %0d/%0d", fwd_a, fwd_b, FWD ? 2 : 0, FWD ? 2 : 0); end
        n_cmp++; if (stall_cnt !== CNT_W'(FWD ? 1 : 3)) begin n_bad++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, FWD ? 1 : 3); end
    endtask

    task automatic test_r0_and_use_bits();
        do_reset();
        set_id(1, 1, 0, 2, 0, 1, 0, 1, 0);          // load writing r0
        next_cycle();
        set_id(1, 0, 1, 0, 1, 1, 6, 0, 0);          // reads r0 twice
        @(negedge clk);
        n_cmp++; if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin n_bad++; $display("FAIL r0_stall: got pc_en=%b bubble=%b want 1 0", pc_en, idex_bubble); end
        next_cycle();
        set_id(1, 1, 0, 2, 0, 1, 3, 1, 0);          // load r3
        @(negedge clk);
        n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_bad++; $display("FAIL r0_fwd: got %0d/%0d want 0/0", fwd_a, fwd_b); end
        next_cycle();
        set_id(1, 3, 0, 3, 0, 0, 0, 0, 0);          // names r3 but reads nothing
        @(negedge clk);
        n_cmp++; if (pc_en !== 1'b1) begin n_bad++; $display("FAIL use_bits: got pc_en=%b want 1", pc_en); end
        n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL r0_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        set_id(1, 1, 0, 2, 0, 1, 3, 1, 0);          // lw r3
        next_cycle();
        set_id(1, 3, 1, 0, 0, 1, 7, 1, 0);          // lw r7 <- [r3]: load-use stall
        @(negedge clk);
        n_cmp++; if (pc_en !== 1'b0) begin n_bad++; $display("FAIL br_prestall: got pc_en=%b want 0", pc_en); end
        next_cycle();
        set_id(1, 3, 1, 0, 0, 1, 7, 1, 1);          // branch resolves taken
        @(negedge clk);
        n_cmp++; if (flush !== 1'b1 || pc_en !== 1'b1 || ifid_en !== 1'b1) begin n_bad++; $display("FAIL br_flush: got flush=%b pc=%b ifid=%b want 1 1 1", flush, pc_en, ifid_en); end
        n_cmp++; if (idex_bubble !== 1'b1) begin n_bad++; $display("FAIL br_bubble: got %b want 1", idex_bubble); end
        next_cycle();
        set_id(1, 7, 1, 0, 0, 0, 0, 0, 0);          // reads r7 of the squashed load
        @(negedge clk);
        n_cmp++; if (pc_en !== 1'b1 || flush !== 1'b0) begin n_bad++; $display("FAIL br_after1: got pc=%b flush=%b want 1 0", pc_en, flush); end
        n_cmp++; if (stall_cnt !== CNT_W'(1)) begin n_bad++; $display("FAIL br_cnt: got %0d want 1", stall_cnt); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (pc_en !== 1'b1) begin n_bad++; $display("FAIL br_after2: got pc=%b want 1", pc_en); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_id(1, 1, 0, 2, 0, 1, 3, 1, 0);
        next_cycle();
        set_id(1, 3, 1, 3, 1, 1, 4, 0, 0);
        next_cycle();                                // one stall already counted
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_bubble !== 1'b1 || flush !== 1'b0) begin n_bad++; $display("FAIL arst_ctl: got pc=%b ifid=%b bub=%b fl=%b want 0 0 1 0", pc_en, ifid_en, idex_bubble, flush); end
        n_cmp++; if (stall_cnt !== '0 || fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_bad++; $display("FAIL arst_regs: got cnt=%0d fwd=%0d/%0d want 0 0/0", stall_cnt, fwd_a, fwd_b); end
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (pc_en !== (i == 3)) begin n_bad++; $display("FAIL arst_init cyc%0d: got %b want %b", i + 1, pc_en, (i == 3)); end
            next_cycle();
        end
    endtask

    function automatic bit writes(input instr_t p, input int s, input bit u);
        return u && p.valid && p.we && p.rd == s && s != 0;
    endfunction

    // Youngest producer of s among the two instructions ahead: EX -> 1, MEM -> 2, none -> 0.
    function automatic int fwd_of(input instr_t hist[$], input int s, input bit u);
        for (int age = 0; age < 2 && age < hist.size(); age++) begin
            if (writes(hist[age], s, u)) return age + 1;
        end
        return 0;
    endfunction

    task automatic test_random();
        instr_t hist[$];
        instr_t cur;
        instr_t none;
        int init_left, exp_cnt, exp_fa, exp_fb, n_cnt, n_fa, n_fb;
        int rs, rt;
        bit v, urs, urt, br, haz, e_pc, e_if, e_bub, e_fl;
        none = '{valid: 0, we: 0, rd: 0, ld: 0};
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        init_left = 3;
        exp_cnt = 0; exp_fa = 0; exp_fb = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            v   = ($urandom_range(0, 9) < 8);
            rs  = $urandom_range(0, 3);
            rt  = $urandom_range(0, 3);
            urs = $urandom_range(0, 3) != 0;
            urt = $urandom_range(0, 1);
            br  = ($urandom_range(0, 15) == 0);
            cur = '{valid: 1, we: ($urandom_range(0, 3) != 0), rd: $urandom_range(0, 3), ld: ($urandom_range(0, 2) == 0)};
            set_id(v, rs, urs, rt, urt, cur.we, cur.rd, cur.ld, br);
            n_cnt = exp_cnt; n_fa = 0; n_fb = 0;
            if (init_left > 0) begin
                {e_pc, e_if, e_bub, e_fl} = 4'b0010;
                init_left--;
            end else begin
                haz = 1'b0;
                for (int age = 0; age < hist.size(); age++) begin
                    if (v && (writes(hist[age], rs, urs) || writes(hist[age], rt, urt)) &&
                        (!FWD || (age == 0 && hist[age].ld))) haz = 1'b1;
                end
                if (br) begin
                    {e_pc, e_if, e_bub, e_fl} = 4'b1111;
                    hist.push_front(none);
                end else if (haz) begin
                    {e_pc, e_if, e_bub, e_fl} = 4'b0010;
                    n_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
                    hist.push_front(none);
                end else begin
                    {e_pc, e_if, e_bub, e_fl} = 4'b1100;
                    if (v && FWD) begin
                        n_fa = fwd_of(hist, rs, urs);
                        n_fb = fwd_of(hist, rt, urt);
                    end
                    hist.push_front(v ? cur : none);
                end
                if (hist.size() > 3) void'(hist.pop_back());
            end
            @(negedge clk);
            n_cmp++; if (pc_en !== e_pc) begin n_bad++; $display("FAIL rnd_pc c%0d: got %b want %b", cyc, pc_en, e_pc); end
            n_cmp++; if (ifid_en !== e_if) begin n_bad++; $display("FAIL rnd_ifid c%0d: got %b want %b", cyc, ifid_en, e_if); end
            n_cmp++; if (idex_bubble !== e_bub) begin n_bad++; $display("FAIL rnd_bubble c%0d: got %b want %b", cyc, idex_bubble, e_bub); end
            n_cmp++; if (flush !== e_fl) begin n_bad++; $display("FAIL rnd_flush c%0d: got %b want %b", cyc, flush, e_fl); end
            n_cmp++; if (stall_cnt !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, stall_cnt, exp_cnt); end
            n_cmp++; if (fwd_a !== 2'(exp_fa)) begin n_bad++; $display("FAIL rnd_fwd_a c%0d: got %0d want %0d", cyc, fwd_a, exp_fa); end
            n_cmp++; if (fwd_b !== 2'(exp_fb)) begin n_bad++; $display("FAIL rnd_fwd_b c%0d: got %0d want %0d", cyc, fwd_b, exp_fb); end
            exp_cnt = n_cnt; exp_fa = n_fa; exp_fb = n_fb;
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        test_reset();
        test_raw();
        test_load_use();
        test_r0_and_use_bits();
        test_branch();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline (IF/ID/EXEC/MEM/WB).
- Tracks destination registers of instructions in flight in EXEC, MEM and WB.
- Detects RAW hazards against the instruction in ID and drives stage enables, bubble insertion and branch flushes.
- Optionally drives the ALU operand forwarding selects.
- Sits beside control_unit. Its outputs gate the PC register, the IF/ID register and the ID/EX register.

Parameters:
REG_AW, 5, register address width (register 0 is hard-wired zero and never hazards)
INIT_CYCLES, 3, cycles the pipe is held after reset so the stage registers drain
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  pipeline clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  ID source register 1
id_rt  in  REG_AW  ID source register 2
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_reg_write  in  1  instruction writes the register file (RegWrite)
id_write_reg  in  REG_AW  destination after RegDest mux
id_mem_read  in  1  instruction is a load
ex_branch_taken  in  1  branch in EXEC resolved taken this cycle
pc_en  out  1  PC register may update
ifid_en  out  1  IF/ID register may update
idex_bubble  out  1  ID/EX loads a NOP instead of ID contents
flush  out  1  IF/ID register is cleared to NOP
fwd_a  out  2  EXEC operand A select: 0 regfile, 1 MEM result, 2 WB result
fwd_b  out  2  EXEC operand B select, same encoding
stall_cnt  out  CNT_W  saturating count of stall cycles since reset

Behaviour:
Reset (async, rst_n low):
- Outputs: pc_en=0, ifid_en=0, idex_bubble=1, flush=0, fwd_a=fwd_b=0, stall_cnt=0.
- All tracker slots invalid; state=INIT; init counter=0.

Tracker:
- Three slots EX, MEM, WB, each holding {valid, we, rd, ld}.
- Every cycle, in state RUN or STALL: WB<=MEM, MEM<=EX.
- EX <= ID fields when the ID instruction issues (id_valid, no stall, no flush); otherwise EX <= invalid (bubble).
- A slot matches source s when: valid && we && rd==s && s!=0 && the corresponding use bit is set.

Hazard (combinational from current slots and ID inputs):
- Without forwarding: hazard = any match against the EX, MEM or WB slot.
- With forwarding: hazard = EX slot match && EX.ld (load-use only).

FSM:
- INIT: pc_en=ifid_en=0, idex_bubble=1. Counts to INIT_CYCLES-1, then goes to RUN.
- RUN: if hazard, go to STALL; otherwise pc_en=ifid_en=1 and idex_bubble=0.
- STALL: pc_en=ifid_en=0, idex_bubble=1, stall_cnt increments. Returns to RUN on the first cycle the hazard clears.
- Stage-control outputs are combinational from state, hazard and branch inputs. stall_cnt and fwd_* are registered.

Branch:
- ex_branch_taken has priority over hazard in RUN and STALL.
- Effect: flush=1, idex_bubble=1, pc_en=1 (PC loads the target), ifid_en=1, next state RUN.
- The ID instruction is not entered into the tracker.
- A stall in progress is abandoned; stall_cnt does not increment that cycle.
- ex_branch_taken is ignored in INIT.

stall_cnt: saturates at all-ones, no wrap.

Simultaneous hazard on rs and rt counts as a single stall cycle.

Optional Feature:
Macro FORWARDING_EN.
- Defined: load-use-only hazard rule. On issue, fwd_a/fwd_b are registered for the instruction entering EXEC:
  - 1 if the current EX slot matches (it becomes MEM);
  - otherwise 2 if the current MEM slot matches;
  - otherwise 0.
  - Youngest producer wins.
- Undefined: full-stall hazard rule; fwd_a and fwd_b are tied to 0.

Decomposition:
- Shared package pipe_pkg holds: state enum {INIT, RUN, STALL}; the tracker slot struct {valid, we, rd, ld}; the fwd select encodings FWD_RF=0, FWD_MEM=1, FWD_WB=2; REG_AW.
- One sub-module, pipe_hazard_detect: the combinational slot-vs-source match and forward-select logic, reused for rs and rt.

Test Plan:
- Reset released -> pc_en=0 and idex_bubble=1 for exactly 3 cycles; pc_en=1 on cycle 4; stall_cnt=0.
- add r3 in ID, then sub reading r3 next cycle, FORWARDING_EN off -> 3 stall cycles (EX, MEM, WB) and stall_cnt=3; with FORWARDING_EN -> 0 stalls and fwd_a=1.
- lw r5 then add r6,r5,r5, FORWARDING_EN on -> 1 stall cycle; then fwd_a=fwd_b=2; stall_cnt=1.
- Source r0 with an in-flight writer to r0 -> no stall, fwd=0.
- Stall active, ex_branch_taken=1 -> same cycle flush=1, pc_en=1, idex_bubble=1; next state RUN; ID instruction absent from MEM two cycles later.
- rst_n asserted mid-STALL -> all outputs return to reset values immediately (async); INIT repeats for 3 cycles.
